ws2812b_rx: RTL

//  Receive side of the WS2812B single-wire GRB protocol: one pixel's data input.

---
 rtl/ws2812b_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B pixel receiver: waits for a RET, decodes one 24-bit GRB word from din, then forwards
// the remainder of the stream on dout the way a real LED in a daisy chain does.
module ws2812b_rx #(
    parameter int unsigned T_THRESH = 60,
    parameter int unsigned MIN_HIGH = 15,
    parameter int unsigned MAX_HIGH = 150,
    parameter int unsigned RET_CYC  = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic        dout,
    output logic [23:0] data,
    output logic        data_valid,
    output logic        ret_det,
    output logic        err,
    output logic        synced
);
    localparam int unsigned HW = $clog2(MAX_HIGH + 1);
    localparam int unsigned LW = $clog2(RET_CYC + 1);

    typedef enum logic [1:0] {StUnsync, StCapture, StForward} state_e;

    state_e        state;
    logic          din_m, din_s, din_d;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [LW-1:0] lcnt, lcnt_nxt;
    logic [4:0]    bitcnt;
    logic [22:0]   shreg;
    logic [23:0]   word;
    logic          rise, fall, ret_hit, long_hit, bit_val, glitch;

    always_comb begin
        rise = din_s & ~din_d;
        fall = ~din_s & din_d;

        // A rise cycle already counts as the first high cycle, so hcnt equals the pulse width.
        hcnt_nxt = hcnt;
        if (rise) begin
            hcnt_nxt = HW'(1);
        end else if (din_s && hcnt != HW'(MAX_HIGH)) begin
            hcnt_nxt = hcnt + HW'(1);
        end

        lcnt_nxt = lcnt;
        if (fall) begin
            lcnt_nxt = LW'(1);
        end else if (!din_s && lcnt != LW'(RET_CYC)) begin
            lcnt_nxt = lcnt + LW'(1);
        end

        // Fire only on the transition into saturation, so one pulse per low / high period.
        ret_hit  = !din_s && (lcnt_nxt == LW'(RET_CYC)) && (fall || lcnt != LW'(RET_CYC));
        long_hit = din_s && (hcnt_nxt == HW'(MAX_HIGH)) && (rise || hcnt != HW'(MAX_HIGH));

        bit_val = (hcnt >= HW'(T_THRESH));
        glitch  = (hcnt < HW'(MIN_HIGH));
        word    = {shreg, bit_val};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StUnsync;
            din_m      <= 1'b0;
            din_s      <= 1'b0;
            din_d      <= 1'b0;
            hcnt       <= '0;
            lcnt       <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            dout       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            ret_det    <= 1'b0;
            err        <= 1'b0;
            synced     <= 1'b0;
        end else begin
            din_m      <= din;
            din_s      <= din_m;
            din_d      <= din_s;
            hcnt       <= hcnt_nxt;
            lcnt       <= lcnt_nxt;
            data_valid <= 1'b0;
            ret_det    <= 1'b0;
            err        <= 1'b0;
            // Loading from din_m makes the registered dout equal din_s.
            dout       <= (state == StForward) ? din_m : 1'b0;

            if (ret_hit) begin
                ret_det <= 1'b1;
                synced  <= 1'b1;
                bitcnt  <= '0;
                shreg   <= '0;
                dout    <= 1'b0;
                state   <= StCapture;
                if (state == StCapture && bitcnt != '0) begin
                    err <= 1'b1;
                end
            end else if (long_hit && state != StUnsync) begin
                err    <= 1'b1;
                synced <= 1'b0;
                bitcnt <= '0;
                shreg  <= '0;
                dout   <= 1'b0;
                state  <= StUnsync;
            end else if (state == StCapture && fall) begin
                if (glitch) begin
                    err    <= 1'b1;
                    synced <= 1'b0;
                    bitcnt <= '0;
                    shreg  <= '0;
                    state  <= StUnsync;
                end else if (bitcnt == 5'd23) begin
                    data       <= word;
                    data_valid <= 1'b1;
                    bitcnt     <= '0;
                    shreg      <= '0;
                    dout       <= din_m;
                    state      <= StForward;
                end else begin
                    shreg  <= word[22:0];
                    bitcnt <= bitcnt + 5'd1;
                end
            end
        end
    end
endmodule
